cam_frame_sequencer: RTL
========================

Name: cam_frame_sequencer

Overview:
- Sequences pixel capture from the camera byte stream (vsync/href/d on pclk) into the frame-buffer write port.
- Arms on request, then waits for a clean frame start.
- Decodes the YUYV byte phase and thresholds each Y byte into a 1-bit mask pixel.
- Generates x/y write addresses, then reports frame completion and overflow errors to the downstream consumer.

Parameters:
H_PIXELS, 320, mask pixels per line (Y bytes per href)
V_LINES, 240, lines per frame
Y_THRESH, 80, luminance threshold; Y < Y_THRESH gives mask=1 (dark pixel)
X_W, 9, width of x address
Y_W, 8, width of y address
CONTINUOUS, 0, 1 = re-arm automatically after each frame

Ports:
pclk  input  1  camera pixel clock; sole clock
reset  input  1  synchronous, active-high reset
arm  input  1  request capture of the next full frame; level, sampled in IDLE
vsync  input  1  camera vertical sync; high during vertical blanking
href  input  1  camera line-valid
d  input  8  camera data byte
busy  output  1  high in WAIT_VS and CAPTURE
wr_en  output  1  frame-buffer write strobe, one per mask pixel
wr_x  output  X_W  pixel column, 0..H_PIXELS-1
wr_y  output  Y_W  pixel row, 0..V_LINES-1
wr_mask  output  1  thresholded pixel
frame_done  output  1  one-cycle pulse at end of captured frame
ovf_err  output  1  sticky: a line or frame exceeded H_PIXELS/V_LINES; cleared on arm acceptance

Behaviour:
- One clock domain (pclk); reset is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, x=0, y=0, phase=0, input registers 0.
- Reset mid-frame aborts the capture. No frame_done is issued.
- Input stage: vsync, href and d are registered once (vs_q, hr_q, d_q). All decisions use the registered copies plus their previous values (vs_q2, hr_q2) for edge detection.
- FSM states:
  - IDLE: on arm=1, clear ovf_err, go to WAIT_VS.
  - WAIT_VS: wait for a vsync falling edge (vs_q2=1, vs_q=0), then go to CAPTURE with x=0, y=0, phase=0. An arm that arrives mid-frame therefore never captures a partial frame.
  - CAPTURE:
    - While hr_q=1, phase toggles every cycle. phase=0 marks a Y byte; phase=1 marks a U/V byte.
    - On a Y byte with x<H_PIXELS and y<V_LINES: in the next cycle assert wr_en=1, with wr_x=x, wr_y=y and wr_mask=(d_q<Y_THRESH). Then x increments.
    - A Y byte that arrives with x==H_PIXELS or y==V_LINES is dropped (no wr_en) and sets ovf_err.
    - On an href falling edge: if x>0, y increments (saturating at V_LINES) and x and phase clear.
    - An href falling edge with x==0 (empty line) does not advance y.
    - A vsync rising edge ends the frame and moves to DONE. Any line still in progress is discarded, with no y increment.
  - DONE: frame_done=1 for exactly one cycle. Next state is WAIT_VS if CONTINUOUS=1, else IDLE.
- Latency: a d byte present on the input at cycle n appears as wr_en and wr_mask at cycle n+2 (input register plus output register).
- wr_en is never asserted outside CAPTURE.
- wr_x and wr_y hold their last values when wr_en=0.
- Boundary rules:
  - arm is ignored while busy.
  - A simultaneous href fall and vsync rise follows the vsync rule: DONE, no y increment.
  - A frame with fewer than V_LINES lines still ends with frame_done; the consumer reads the line count from the last wr_y.
  - href high while in WAIT_VS or IDLE is ignored.

Decomposition:
- Shared package cam_pkg holds:
  - the state typedef (IDLE, WAIT_VS, CAPTURE, DONE);
  - the default H_PIXELS/V_LINES/Y_THRESH constants;
  - the byte-phase enum (Y0, U, Y1, V) used by other camera blocks.
- Natural sub-module: cam_sync_edge. It contains the input register stage plus rise/fall detection for vsync and href, and its outputs are vs_rise, vs_fall, hr_fall, hr_q and d_q.

Test Plan:
- Reset during CAPTURE at x=37 -> next cycle busy=0, wr_en=0, x/y=0; no frame_done.
- arm, vsync 1->0, one href line of 640 bytes with Y=50 (even) and 200 (odd) -> 320 wr_en pulses, wr_x 0..319, wr_y=0, wr_mask=1; first wr_en two cycles after the first byte.
- 240 lines of 640 bytes, then vsync rise -> 76,800 writes, last wr_x=319/wr_y=239, single frame_done pulse, ovf_err=0.
- Line of 700 bytes -> 320 writes, bytes 641+ dropped, ovf_err=1 and held until the next accepted arm.
- arm asserted mid-frame (vsync low, href toggling) -> no wr_en until after the next vsync fall; the capture starts at wr_y=0.
- CONTINUOUS=1, two frames -> two frame_done pulses, busy stays high between them; Y byte exactly 80 -> wr_mask=0, Y byte 79 -> wr_mask=1.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared camera-path types and default frame geometry.
// Used by the frame sequencer and other blocks on the camera byte stream.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } cam_state_e;

    // YUYV byte order within a line; Y bytes sit on even positions.
    typedef enum logic [1:0] {
        Y0,
        U,
        Y1,
        V
    } cam_phase_e;

    localparam int CAM_H_PIXELS = 320;
    localparam int CAM_V_LINES  = 240;
    localparam int CAM_Y_THRESH = 80;

    function automatic logic is_y_phase(input cam_phase_e ph);
        return (ph == Y0) || (ph == Y1);
    endfunction

    function automatic cam_phase_e next_phase(input cam_phase_e ph);
        return cam_phase_e'(ph + 2'd1);
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers the raw camera inputs once and derives vsync/href edges
// from the registered copy and its one-cycle-delayed value.
module cam_sync_edge (
    input  logic       pclk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] d,
    output logic       vs_rise,
    output logic       vs_fall,
    output logic       hr_fall,
    output logic       hr_q,
    output logic [7:0] d_q
);

    logic vs_q;
    logic vs_q2;
    logic hr_q2;

    always_ff @(posedge pclk) begin
        if (reset) begin
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            hr_q  <= 1'b0;
            hr_q2 <= 1'b0;
            d_q   <= 8'd0;
        end else begin
            vs_q  <= vsync;
            vs_q2 <= vs_q;
            hr_q  <= href;
            hr_q2 <= hr_q;
            d_q   <= d;
        end
    end

    assign vs_rise = vs_q & ~vs_q2;
    assign vs_fall = ~vs_q & vs_q2;
    assign hr_fall = ~hr_q & hr_q2;

endmodule

// File: rtl/cam_frame_sequencer.sv
// Captures one camera frame after arm, thresholds Y bytes into mask pixels
// and emits frame-buffer writes with x/y addresses, frame_done and overflow.
module cam_frame_sequencer
    import cam_pkg::*;
#(
    parameter int H_PIXELS   = CAM_H_PIXELS,
    parameter int V_LINES    = CAM_V_LINES,
    parameter int Y_THRESH   = CAM_Y_THRESH,
    parameter int X_W        = 9,
    parameter int Y_W        = 8,
    parameter int CONTINUOUS = 0
) (
    input  logic           pclk,
    input  logic           reset,
    input  logic           arm,
    input  logic           vsync,
    input  logic           href,
    input  logic [7:0]     d,
    output logic           busy,
    output logic           wr_en,
    output logic [X_W-1:0] wr_x,
    output logic [Y_W-1:0] wr_y,
    output logic           wr_mask,
    output logic           frame_done,
    output logic           ovf_err
);

    localparam logic [X_W-1:0] H_MAX  = X_W'(H_PIXELS);
    localparam logic [Y_W-1:0] V_MAX  = Y_W'(V_LINES);
    localparam logic [7:0]     THRESH = 8'(Y_THRESH);

    logic       vs_rise;
    logic       vs_fall;
    logic       hr_fall;
    logic       hr_q;
    logic [7:0] d_q;

    cam_sync_edge u_sync (
        .pclk    (pclk),
        .reset   (reset),
        .vsync   (vsync),
        .href    (href),
        .d       (d),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall),
        .hr_fall (hr_fall),
        .hr_q    (hr_q),
        .d_q     (d_q)
    );

    cam_state_e     state_q, state_d;
    cam_phase_e     phase_q, phase_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           ovf_q, ovf_d;
    logic           wr_en_q, wr_en_d;
    logic [X_W-1:0] wr_x_q, wr_x_d;
    logic [Y_W-1:0] wr_y_q, wr_y_d;
    logic           wr_mask_q, wr_mask_d;

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= Y0;
            x_q       <= '0;
            y_q       <= '0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_mask_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_x_q    <= wr_x_d;
            wr_y_q    <= wr_y_d;
            wr_mask_q <= wr_mask_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        x_d       = x_q;
        y_d       = y_q;
        ovf_d     = ovf_q;
        wr_en_d   = 1'b0;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        wr_mask_d = wr_mask_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    ovf_d   = 1'b0;
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d = CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = Y0;
                end
            end
            CAPTURE: begin
                // End of frame wins over everything, including a coincident href fall.
                if (vs_rise) begin
                    state_d = DONE;
                end else begin
                    if (hr_q) begin
                        phase_d = next_phase(phase_q);
                        if (is_y_phase(phase_q)) begin
                            if ((x_q < H_MAX) && (y_q < V_MAX)) begin
                                wr_en_d   = 1'b1;
                                wr_x_d    = x_q;
                                wr_y_d    = y_q;
                                wr_mask_d = (d_q < THRESH);
                                x_d       = x_q + X_W'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                    if (hr_fall) begin
                        phase_d = Y0;
                        if (x_q != '0) begin
                            x_d = '0;
                            if (y_q < V_MAX) begin
                                y_d = y_q + Y_W'(1);
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_d = (CONTINUOUS != 0) ? WAIT_VS : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // In continuous mode DONE is only a pass-through to the next frame, so busy stays up.
    assign busy       = (state_q == WAIT_VS) || (state_q == CAPTURE) ||
                        ((CONTINUOUS != 0) && (state_q == DONE));
    assign frame_done = (state_q == DONE);
    assign ovf_err    = ovf_q;
    assign wr_en      = wr_en_q;
    assign wr_x       = wr_x_q;
    assign wr_y       = wr_y_q;
    assign wr_mask    = wr_mask_q;

endmodule
